// File: rtl/speed_selector.sv
`timescale 1ns/1ps
// Doubles/halves a saturating 26-bit speed word from two debounced active-low buttons.
// Optional auto-repeat while a button is held: define SPEED_SELECTOR_AUTO_REPEAT_EN.
module speed_selector #(
  parameter int MIN_SPEED       = 1,
  parameter int MAX_SPEED       = 1000,
  parameter int DEFAULT_SPEED   = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up_n,
  input  logic        btn_down_n,
  output logic [25:0] speed,
  output logic        changed,
  output logic        at_min,
  output logic        at_max
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [25:0] MIN_W = 26'(MIN_SPEED);
  localparam logic [25:0] MAX_W = 26'(MAX_SPEED);
  localparam logic [25:0] DEF_W = 26'(DEFAULT_SPEED);
  localparam logic DEF_AT_MIN = (DEFAULT_SPEED == MIN_SPEED);
  localparam logic DEF_AT_MAX = (DEFAULT_SPEED == MAX_SPEED);

  if (MIN_SPEED < 1 || MAX_SPEED < MIN_SPEED || MAX_SPEED > 67108863 ||
      DEFAULT_SPEED < MIN_SPEED || DEFAULT_SPEED > MAX_SPEED ||
      DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_err
    $error("speed_selector: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  // Bit 0 = up button, bit 1 = down button; both idle high.
  logic [1:0] sync0, sync1;
  logic [1:0] press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= 2'b11;
      sync1 <= 2'b11;
    end else begin
      sync0 <= {btn_down_n, btn_up_n};
      sync1 <= sync0;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
    db_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level;
    logic          press_db;

    assign level = sync1[b];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // The first stable cycle is spent entering a WAIT state, so the count
    // terminates one short to accept exactly DEBOUNCE_CYCLES stable cycles.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_db  = 1'b0;
      case (state)
        RELEASED: begin
          if (!level) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (level) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            press_db  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: begin
          if (level) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!level) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef SPEED_SELECTOR_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_ev;

    assign rep_ev = (state == HELD) && !level && (rep_cnt == REP_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rep_cnt <= '0;
      end else if (state == HELD && !level) begin
        rep_cnt <= rep_ev ? '0 : rep_cnt + RW'(1);
      end else begin
        rep_cnt <= '0;
      end
    end

    assign press[b] = press_db | rep_ev;
`else
    assign press[b] = press_db;
`endif
  end

  logic [26:0] dbl;
  logic [25:0] half;
  logic [25:0] speed_nxt;

  assign dbl  = {speed, 1'b0};
  assign half = {1'b0, speed[25:1]};

  always_comb begin
    speed_nxt = speed;
    case (press)
      2'b01: speed_nxt = (dbl > {1'b0, MAX_W}) ? MAX_W : dbl[25:0];
      2'b10: speed_nxt = (half < MIN_W) ? MIN_W : half;
      default: speed_nxt = speed;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed   <= DEF_W;
      changed <= 1'b0;
      at_min  <= DEF_AT_MIN;
      at_max  <= DEF_AT_MAX;
    end else begin
      speed   <= speed_nxt;
      changed <= (speed_nxt != speed);
      at_min  <= (speed_nxt == MIN_W);
      at_max  <= (speed_nxt == MAX_W);
    end
  end

endmodule

// File: tb/tb_speed_selector.sv
`timescale 1ns/1ps
// Directed bench for speed_selector with DEBOUNCE_CYCLES=4, MIN=1, MAX=10, DEFAULT=1.
module tb_speed_selector;

`ifdef SPEED_SELECTOR_AUTO_REPEAT_EN
  localparam int HOLD = 10;
`else
  localparam int HOLD = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up_n;
  logic        btn_down_n;
  logic [25:0] speed;
  logic        changed;
  logic        at_min;
  logic        at_max;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  speed_selector #(
    .MIN_SPEED(1),
    .MAX_SPEED(10),
    .DEFAULT_SPEED(1),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n),
    .speed(speed),
    .changed(changed),
    .at_min(at_min),
    .at_max(at_max)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the requested buttons for 'hold' cycles then releases them long
  // enough for the debouncers to settle; reports changed pulses seen.
  task automatic run_press(input logic up, input logic dn, input int hold,
                           output int pulses, output int first);
    pulses = 0;
    first  = -1;
    btn_up_n   = ~up;
    btn_down_n = ~dn;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (changed) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (changed) pulses++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    repeat (3) tick();
    total++;
    if (speed !== 26'd1) begin
      bad++; $display("FAIL reset_hold_speed got=%0d want=1", speed);
    end
    reset = 1'b1;
    tick();
    total++;
    if (speed !== 26'd1) begin
      bad++; $display("FAIL reset_speed got=%0d want=1", speed);
    end
    total++;
    if ({at_min, at_max, changed} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got=%b want=100", {at_min, at_max, changed});
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    for (int seg = 0; seg < 3; seg++) begin
      btn_up_n = (seg == 1);
      for (int i = 0; i < 3; i++) begin
        tick();
        if (changed) pulses++;
      end
    end
    btn_up_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (changed) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses);
    end
    total++;
    if (speed !== 26'd1) begin
      bad++; $display("FAIL glitch_speed got=%0d want=1", speed);
    end
  endtask

  task automatic test_single_press();
    int p, f;
    run_press(1'b1, 1'b0, HOLD, p, f);
    total++;
    if (p !== 1) begin
      bad++; $display("FAIL single_pulses got=%0d want=1", p);
    end
    total++;
    if (f !== 6) begin
      bad++; $display("FAIL single_latency got=%0d want=6", f);
    end
    total++;
    if (speed !== 26'd2 || at_min !== 1'b0 || at_max !== 1'b0) begin
      bad++; $display("FAIL single_speed got=%0d/%b%b want=2/00", speed, at_min, at_max);
    end
  endtask

  task automatic test_async_reset();
    int p, f;
    run_press(1'b1, 1'b0, HOLD, p, f);
    total++;
    if (speed !== 26'd4 || p !== 1) begin
      bad++; $display("FAIL pre_reset_speed got=%0d/%0d want=4/1", speed, p);
    end
    reset = 1'b0;
    #1;
    total++;
    if (speed !== 26'd1 || at_min !== 1'b1 || changed !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b%b want=1/10", speed, at_min, changed);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    int p, f;
    int exp_up[5]   = '{2, 4, 8, 10, 10};
    int exp_upp[5]  = '{1, 1, 1, 1, 0};
    int exp_dn[12]  = '{5, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_dnp[12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      run_press(1'b1, 1'b0, HOLD, p, f);
      total++;
      if (speed !== 26'(exp_up[i]) || p !== exp_upp[i]) begin
        bad++; $display("FAIL sat_up[%0d] got=%0d/%0d want=%0d/%0d", i, speed, p, exp_up[i], exp_upp[i]);
      end
      if (i >= 3) begin
        total++;
        if (at_max !== 1'b1) begin
          bad++; $display("FAIL sat_at_max[%0d] got=%b want=1", i, at_max);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      run_press(1'b0, 1'b1, HOLD, p, f);
      total++;
      if (speed !== 26'(exp_dn[i]) || p !== exp_dnp[i]) begin
        bad++; $display("FAIL sat_dn[%0d] got=%0d/%0d want=%0d/%0d", i, speed, p, exp_dn[i], exp_dnp[i]);
      end
    end
    total++;
    if ({at_min, at_max} !== 2'b10) begin
      bad++; $display("FAIL sat_floor_flags got=%b want=10", {at_min, at_max});
    end
  endtask

  task automatic test_simultaneous();
    int p, f;
    run_press(1'b1, 1'b1, HOLD, p, f);
    total++;
    if (p !== 0 || speed !== 26'd1) begin
      bad++; $display("FAIL simul got=%0d/%0d want=1/0", speed, p);
    end
    run_press(1'b1, 1'b0, HOLD, p, f);
    total++;
    if (p !== 1 || f !== 6 || speed !== 26'd2) begin
      bad++; $display("FAIL after_simul got=%0d/%0d/%0d want=2/1/6", speed, p, f);
    end
  endtask

  task automatic test_reset_while_held();
    int pulses, first;
    pulses = 0;
    first  = -1;
    btn_up_n = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    total++;
    if (speed !== 26'd1) begin
      bad++; $display("FAIL held_reset_speed got=%0d want=1", speed);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (changed) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    btn_up_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (changed) pulses++;
    end
    total++;
    if (pulses !== 1 || first !== 6 || speed !== 26'd2) begin
      bad++; $display("FAIL held_reset_event got=%0d/%0d/%0d want=2/1/6", speed, pulses, first);
    end
  endtask

`ifdef SPEED_SELECTOR_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int p, f;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_press(1'b1, 1'b0, 40, p, f);
    total++;
    if (p !== 4 || f !== 6) begin
      bad++; $display("FAIL repeat_pulses got=%0d/%0d want=4/6", p, f);
    end
    total++;
    if (speed !== 26'd10 || at_max !== 1'b1) begin
      bad++; $display("FAIL repeat_speed got=%0d/%b want=10/1", speed, at_max);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_async_reset();
    test_saturation();
    test_simultaneous();
    test_reset_while_held();
`ifdef SPEED_SELECTOR_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speed_selector.md
Name: speed_selector

Overview:
- Produces the 26-bit `speed` word consumed by the clock divider stage.
- Takes two raw, active-low push-buttons (faster / slower) and synchronises and debounces each one.
- Each debounced press doubles or halves the current speed, saturating at a configurable minimum and maximum.
- Also reports status flags and a one-cycle change pulse for display or LED logic.

Parameters:
- MIN_SPEED, 1: lowest legal speed value (must be ≥1).
- MAX_SPEED, 1000: highest legal speed value (≤ 26-bit max; ≤ divider base/2).
- DEFAULT_SPEED, 1: value loaded at reset (MIN_SPEED ≤ DEFAULT_SPEED ≤ MAX_SPEED).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- REPEAT_CYCLES, 25000000: hold interval between auto-repeat steps (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset; all state cleared while low
- btn_up_n  input  1  raw "faster" button, asynchronous, low = pressed
- btn_down_n  input  1  raw "slower" button, asynchronous, low = pressed
- speed  output  26  current speed word, registered
- changed  output  1  one-cycle pulse in the cycle `speed` takes a new value
- at_min  output  1  high when speed == MIN_SPEED
- at_max  output  1  high when speed == MAX_SPEED

Behaviour:
- Reset (reset low, async):
  - speed = DEFAULT_SPEED; changed = 0; at_min/at_max reflect DEFAULT_SPEED.
  - Synchronisers = 1 (released); debounce FSMs = RELEASED; counters = 0.
- Input sync: two-flop synchroniser per button. Debounce logic sees only the synchronised level.
- Per-button debounce FSM, states:
  - RELEASED: synced level 0 → PRESS_WAIT, count = 0.
  - PRESS_WAIT: level 0 → count += 1; when count reaches DEBOUNCE_CYCLES-1 → HELD and assert internal press event for 1 cycle. Level 1 at any point → RELEASED, count = 0.
  - HELD: synced level 1 → RELEASE_WAIT, count = 0.
  - RELEASE_WAIT: level 1 for DEBOUNCE_CYCLES cycles → RELEASED. Level 0 → HELD. Release produces no event.
- Glitch rule: a level held for fewer than DEBOUNCE_CYCLES consecutive cycles never causes a transition.
- Latency: press event fires in the cycle where the synced level has been low DEBOUNCE_CYCLES consecutive cycles. speed/changed update on the next clock edge.
- Step rules, evaluated on a press event:
  - up only: next = speed<<1. If speed > MAX_SPEED/2, next = MAX_SPEED. Compute in 27 bits, no wrap.
  - down only: next = speed>>1. If result < MIN_SPEED, next = MIN_SPEED.
  - up and down events in the same cycle: no change, changed stays 0.
  - changed = 1 only if next != speed. A press at saturation leaves speed unchanged and changed = 0.
- at_min/at_max: registered together with speed, so they are coherent with it in every cycle.
- Reset asserted mid-debounce or mid-hold: abort immediately. A still-held button after reset release must debounce again and then produces exactly one event.

Optional Feature:
- Macro: SPEED_SELECTOR_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - Every REPEAT_CYCLES cycles of continuous HELD, an additional press event is generated for that button.
  - The counter clears on leaving HELD and on reset.
  - Saturation rules apply to repeat events unchanged.
- Undefined: no repeat counter is synthesised; one event per debounced press only; REPEAT_CYCLES is ignored.

Test Plan (DEBOUNCE_CYCLES=4, MIN_SPEED=1, MAX_SPEED=10, DEFAULT_SPEED=1, macro undefined unless noted):
- Reset: hold reset low with buttons idle, then release → speed=1, at_min=1, at_max=0, changed=0. Assert reset while speed=4 → speed=1 asynchronously, before the next clk edge.
- Single press: btn_up_n low for 20 cycles → exactly one update 1→2 with a one-cycle changed pulse, 2+4+1 cycles after the first sampled low level (±1 for the sync edge). Release → no further change.
- Glitch: btn_up_n low for 3 cycles, high for 3, low for 3 → speed stays 1, changed never asserted.
- Saturation: five debounced up presses → 2, 4, 8, 10, 10. at_max=1 after the fourth press; fifth press gives changed=0. Then twelve down presses → floor at 1, at_min=1.
- Simultaneous: both buttons driven low on the same cycle for 20 cycles → speed unchanged, changed=0. Both released → FSMs return to RELEASED.
- With SPEED_SELECTOR_AUTO_REPEAT_EN, REPEAT_CYCLES=8: hold btn_up_n for 40 cycles → 1→2 on debounce, then +1 doubling every 8 cycles held (4, 8, 10), stopping at 10.
